// File: rtl/mux_vector_sequencer.sv
// mux_vector_sequencer
//   Synchronous stimulus/response checker for a 2:1 mux. Sweeps all eight
//   (a,b,s) combinations, waits SETTLE_CYCLES after driving each one, samples
//   the mux output and accumulates a pass/fail summary suitable for LEDs.
//
// Parameters
//   SETTLE_CYCLES    cycles between driving a vector and sampling x_i (1..15, 0 acts as 1)
//   SEL_B_WHEN_HIGH  golden function: 1 -> x = s ? b : a, 0 -> x = s ? a : b
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      launches a sweep when high in IDLE/DONE; ignored while busy
//   x_i        mux output under test
//   a_o/b_o/s_o registered mux inputs A, B and select S
//   busy       high from the first DRIVE through the last SAMPLE
//   done       high in DONE, held until the next start or reset
//   pass       valid with done: 1 iff err_count == 0
//   err_count  number of mismatching vectors (0..8)
//   fail_vec   bit k set iff vector k mismatched
//   vec_idx    index of the vector currently or last driven
//
// Optional build macro
//   MUXSEQ_STOP_ON_FAIL_EN  stop the sweep at the first mismatch
module mux_vector_sequencer #(
    parameter int unsigned SETTLE_CYCLES   = 1,
    parameter bit          SEL_B_WHEN_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       x_i,
    output logic       a_o,
    output logic       b_o,
    output logic       s_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec,
    output logic [2:0] vec_idx
);

    localparam int unsigned SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 :
                                          (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_EFF);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    state_e     state_q;
    logic [3:0] settle_q;
    logic       a_q, b_q, s_q;
    logic       busy_q, done_q, pass_q;
    logic [3:0] err_q;
    logic [7:0] fail_q;
    logic [2:0] idx_q;

    logic expected;
    logic mismatch;
    logic last_sample;

    // Golden mux evaluated on the registered vector currently applied.
    always_comb begin
        if (SEL_B_WHEN_HIGH) expected = s_q ? b_q : a_q;
        else                 expected = s_q ? a_q : b_q;
        mismatch = (x_i != expected);
`ifdef MUXSEQ_STOP_ON_FAIL_EN
        last_sample = mismatch || (idx_q == 3'd7);
`else
        last_sample = (idx_q == 3'd7);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            s_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_q   <= '0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // done/pass become visible one cycle after entering DONE.
                    if (state_q == DONE) begin
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0);
                    end
                    if (start) begin
                        err_q   <= '0;
                        fail_q  <= '0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    s_q      <= idx_q[2];
                    a_q      <= idx_q[1];
                    b_q      <= idx_q[0];
                    settle_q <= SETTLE_LOAD;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q <= 4'd1) begin
                        settle_q <= '0;
                        state_q  <= SAMPLE;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_q         <= err_q + 4'd1;
                        fail_q[idx_q] <= 1'b1;
                    end
                    if (last_sample) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 3'd1;
                        state_q <= DRIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign s_o       = s_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;
    assign vec_idx   = idx_q;

endmodule
